// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - staggered per-domain reset/clock-enable sequencer with sw reset quiesce handshake
module rst_seq_ctrl #(
    parameter int NUM_DOM         = 4,
    parameter int RST_CYCLES      = 5,
    parameter int STAGGER         = 2,
    parameter int QUIESCE_TIMEOUT = 64
) (
    input  logic               clk_fr,
    input  logic               rst,
    input  logic               sw_rst_req,
    input  logic [NUM_DOM-1:0] quiesce_ack,
    output logic               sw_rst_ack,
    output logic               quiesce_req,
    output logic [NUM_DOM-1:0] dom_clk_en,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               busy,
    output logic               timeout_err,
    output logic [2:0]         state
);
    localparam int MAX_A = (RST_CYCLES > STAGGER * NUM_DOM) ? RST_CYCLES : STAGGER * NUM_DOM;
    localparam int MAX_V = (MAX_A > QUIESCE_TIMEOUT) ? MAX_A : QUIESCE_TIMEOUT;
    localparam int CW    = $clog2(MAX_V) + 1;

    localparam logic [CW-1:0]      HOLD_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]      STAG_LAST = CW'(STAGGER - 1);
    localparam logic [CW-1:0]      QTO_LAST  = CW'(QUIESCE_TIMEOUT - 1);
    localparam logic [NUM_DOM-1:0] ALL_DOM   = '1;
    localparam logic [NUM_DOM-1:0] DOM0      = NUM_DOM'(1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_RUN     = 3'd2,
        S_QUIESCE = 3'd3,
        S_ASSERT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sw_flag_q, sw_flag_d;
    logic               sw_rst_ack_d, quiesce_req_d, busy_d, timeout_err_d;
    logic [NUM_DOM-1:0] dom_clk_en_d, dom_rst_n_d;

    assign state = state_q;

    always_ff @(posedge clk_fr) begin
        if (rst) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            sw_flag_q   <= 1'b0;
            sw_rst_ack  <= 1'b0;
            quiesce_req <= 1'b0;
            dom_clk_en  <= '0;
            dom_rst_n   <= '0;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sw_flag_q   <= sw_flag_d;
            sw_rst_ack  <= sw_rst_ack_d;
            quiesce_req <= quiesce_req_d;
            dom_clk_en  <= dom_clk_en_d;
            dom_rst_n   <= dom_rst_n_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sw_flag_d     = sw_flag_q;
        sw_rst_ack_d  = 1'b0;
        quiesce_req_d = quiesce_req;
        dom_clk_en_d  = dom_clk_en;
        dom_rst_n_d   = dom_rst_n;
        timeout_err_d = timeout_err;
        case (state_q)
            S_HOLD: begin
                dom_clk_en_d = ALL_DOM;
                if (cnt_q == HOLD_LAST) begin
                    state_d     = S_RELEASE;
                    cnt_d       = '0;
                    dom_rst_n_d = (STAGGER == 0) ? ALL_DOM : DOM0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Domains release LSB first, so the top bit marks the last one out.
            S_RELEASE: begin
                if (dom_rst_n[NUM_DOM-1]) begin
                    state_d      = S_RUN;
                    cnt_d        = '0;
                    sw_rst_ack_d = sw_flag_q;
                    sw_flag_d    = 1'b0;
                end else if (cnt_q == STAG_LAST) begin
                    dom_rst_n_d = (dom_rst_n << 1) | DOM0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (sw_rst_req) begin
                    state_d       = S_QUIESCE;
                    quiesce_req_d = 1'b1;
                    sw_flag_d     = 1'b1;
                    cnt_d         = '0;
                end
            end
            S_QUIESCE: begin
                if (&quiesce_ack || cnt_q == QTO_LAST) begin
                    state_d       = S_ASSERT;
                    quiesce_req_d = 1'b0;
                    dom_rst_n_d   = '0;
                    dom_clk_en_d  = '0;
                    if (!(&quiesce_ack)) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ASSERT: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_RUN);
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - self-checking bench for rst_seq_ctrl against an edge-count reference model
module tb_rst_seq_ctrl;
    localparam int ND    = 4;
    localparam int RC    = 5;
    localparam int ST    = 2;
    localparam int QT    = 64;
    localparam int T_RUN = RC + (ND - 1) * ST + 1;

    logic clk_fr = 1'b0;
    always #5 clk_fr = ~clk_fr;

    logic          rst = 1'b1, sw_rst_req = 1'b0;
    logic [ND-1:0] quiesce_ack = '0;
    logic          sw_rst_ack, quiesce_req, busy, timeout_err;
    logic [ND-1:0] dom_clk_en, dom_rst_n;
    logic [2:0]    state;

    rst_seq_ctrl #(.NUM_DOM(ND), .RST_CYCLES(RC), .STAGGER(ST), .QUIESCE_TIMEOUT(QT)) u0 (
        .clk_fr(clk_fr), .rst(rst), .sw_rst_req(sw_rst_req), .quiesce_ack(quiesce_ack),
        .sw_rst_ack(sw_rst_ack), .quiesce_req(quiesce_req), .dom_clk_en(dom_clk_en),
        .dom_rst_n(dom_rst_n), .busy(busy), .timeout_err(timeout_err), .state(state)
    );

    logic       rst1 = 1'b1, req1 = 1'b0;
    logic [2:0] ack1 = '0;
    logic       sw_rst_ack1, quiesce_req1, busy1, timeout_err1;
    logic [2:0] dom_clk_en1, dom_rst_n1, state1;

    rst_seq_ctrl #(.NUM_DOM(3), .RST_CYCLES(1), .STAGGER(0), .QUIESCE_TIMEOUT(1)) u1 (
        .clk_fr(clk_fr), .rst(rst1), .sw_rst_req(req1), .quiesce_ack(ack1),
        .sw_rst_ack(sw_rst_ack1), .quiesce_req(quiesce_req1), .dom_clk_en(dom_clk_en1),
        .dom_rst_n(dom_rst_n1), .busy(busy1), .timeout_err(timeout_err1), .state(state1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_t = edges since the sequence (re)started; m_ph 0 = power sequence/run, 3 = quiesce, 4 = assert.
    int m_t = 0, m_ph = 0, m_q = 0;
    bit m_sw = 0, m_terr = 0, m_pulse = 0;

    task automatic model_step();
        m_pulse = 0;
        if (rst) begin
            m_t = 0; m_ph = 0; m_sw = 0; m_terr = 0;
        end else begin
            case (m_ph)
                0: begin
                    if (m_t >= T_RUN) begin
                        if (sw_rst_req) begin m_ph = 3; m_q = 0; m_sw = 1; end
                    end else begin
                        m_t++;
                        if (m_t == T_RUN && m_sw) begin m_pulse = 1; m_sw = 0; end
                    end
                end
                3: begin
                    m_q++;
                    if (&quiesce_ack) m_ph = 4;
                    else if (m_q == QT) begin m_ph = 4; m_terr = 1; end
                end
                default: begin m_ph = 0; m_t = 0; end
            endcase
        end
    endtask

    function automatic logic [14:0] expect_vec();
        logic [2:0]    st;
        logic          bsy, qr;
        logic [ND-1:0] rn, ce;
        rn = '0; ce = '0; qr = 1'b0; bsy = 1'b1; st = 3'd4;
        if (m_ph == 0) begin
            ce = (m_t >= 1) ? {ND{1'b1}} : {ND{1'b0}};
            for (int i = 0; i < ND; i++) rn[i] = (m_t >= RC + i * ST);
            if (m_t >= T_RUN) begin st = 3'd2; bsy = 1'b0; end
            else if (m_t >= RC) st = 3'd1;
            else st = 3'd0;
        end else if (m_ph == 3) begin
            ce = {ND{1'b1}}; rn = {ND{1'b1}}; qr = 1'b1; st = 3'd3;
        end
        return {st, bsy, rn, ce, qr, m_pulse, m_terr};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {state, busy, dom_rst_n, dom_clk_en, quiesce_req, sw_rst_ack, timeout_err};
    endfunction

    task automatic tick();
        @(posedge clk_fr);
        model_step();
        @(negedge clk_fr);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sw_rst_req = 1'($urandom); quiesce_ack = ND'($urandom);
            tick();
            n_cmp++;
            if (dut_vec() !== 15'b000_1_0000_0000_000) begin
                n_err++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), 15'b000_1_0000_0000_000);
            end
        end
    endtask

    task automatic test_power_on();
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            sw_rst_req  = (c <= 11);
            quiesce_ack = ND'($urandom);
            tick();
            n_cmp++;
            if (dut_vec() !== expect_vec()) begin
                n_err++; $display("FAIL power_on edge=%0d got=%h exp=%h", c, dut_vec(), expect_vec());
            end
            if (c == 12) begin
                n_cmp++;
                if (state !== 3'd2 || busy !== 1'b0) begin
                    n_err++; $display("FAIL run_at_edge12 state=%0d busy=%b exp state=2 busy=0", state, busy);
                end
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_sw_reset();
        int ack_seen = 0;
        for (int k = 0; k <= 16; k++) begin
            sw_rst_req  = (k == 0);
            quiesce_ack = (k == 3) ? {ND{1'b1}} : ND'($urandom_range(0, 14));
            tick();
            n_cmp++;
            if (dut_vec() !== expect_vec()) begin
                n_err++; $display("FAIL sw_reset E+%0d got=%h exp=%h", k, dut_vec(), expect_vec());
            end
            if (sw_rst_ack) ack_seen++;
        end
        n_cmp++;
        if (ack_seen != 1 || sw_rst_ack !== 1'b1 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL sw_ack_pulse count=%0d last=%b terr=%b exp count=1 last=1 terr=0", ack_seen, sw_rst_ack, timeout_err);
        end
    endtask

    task automatic test_timeout();
        int q_cycles = 0;
        for (int k = 0; k < 80; k++) begin
            sw_rst_req  = (k == 0);
            quiesce_ack = 4'b0111;
            tick();
            n_cmp++;
            if (dut_vec() !== expect_vec()) begin
                n_err++; $display("FAIL timeout k=%0d got=%h exp=%h", k, dut_vec(), expect_vec());
            end
            if (state == 3'd3) q_cycles++;
        end
        n_cmp++;
        if (q_cycles != QT || state !== 3'd2) begin
            n_err++; $display("FAIL quiesce_len got=%0d state=%0d exp=%0d state=2", q_cycles, state, QT);
        end
        for (int k = 0; k < 18; k++) begin
            sw_rst_req  = (k == 0);
            quiesce_ack = (k == 1) ? {ND{1'b1}} : 4'b0011;
            tick();
            n_cmp++;
            if (dut_vec() !== expect_vec()) begin
                n_err++; $display("FAIL timeout_sticky k=%0d got=%h exp=%h", k, dut_vec(), expect_vec());
            end
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_err++; $display("FAIL timeout_err_kept got=%b exp=1", timeout_err);
        end
    endtask

    task automatic test_rst_in_quiesce();
        int ack_seen = 0;
        for (int k = 0; k < 3; k++) begin
            sw_rst_req = (k == 0); quiesce_ack = '0;
            tick();
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec() !== 15'b000_1_0000_0000_000) begin
            n_err++; $display("FAIL rst_mid_quiesce got=%h exp=%h", dut_vec(), 15'b000_1_0000_0000_000);
        end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            quiesce_ack = ND'($urandom);
            tick();
            n_cmp++;
            if (dut_vec() !== expect_vec()) begin
                n_err++; $display("FAIL repowered k=%0d got=%h exp=%h", k, dut_vec(), expect_vec());
            end
            if (sw_rst_ack) ack_seen++;
        end
        n_cmp++;
        if (ack_seen != 0) begin
            n_err++; $display("FAIL no_ack_after_rst got=%0d exp=0", ack_seen);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            rst         = ($urandom_range(0, 149) == 0);
            sw_rst_req  = ($urandom_range(0, 7) == 0);
            quiesce_ack = ($urandom_range(0, 5) == 0) ? {ND{1'b1}} : ND'($urandom);
            tick();
            n_cmp++;
            if (dut_vec() !== expect_vec()) begin
                n_err++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), expect_vec());
            end
        end
        rst = 1'b0; sw_rst_req = 1'b0;
    endtask

    task automatic test_stagger0();
        logic [2:0]  t_rst, t_req;
        logic [2:0]  t_ack [11];
        logic [12:0] t_exp [11];
        logic [12:0] got;
        t_rst = 3'b001; t_req = 3'b000;
        t_ack = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
        t_exp = '{13'b000_1_000_000_000, 13'b001_1_111_111_000, 13'b010_0_111_111_000,
                  13'b011_1_111_111_100, 13'b100_1_000_000_000, 13'b000_1_000_000_000,
                  13'b001_1_111_111_000, 13'b010_0_111_111_010, 13'b011_1_111_111_100,
                  13'b100_1_000_000_001, 13'b000_1_000_000_001};
        for (int s = 0; s < 11; s++) begin
            rst1 = (s == 0);
            req1 = (s == 3 || s == 8);
            ack1 = t_ack[s];
            tick();
            got = {state1, busy1, dom_rst_n1, dom_clk_en1, quiesce_req1, sw_rst_ack1, timeout_err1};
            n_cmp++;
            if (got !== t_exp[s]) begin
                n_err++; $display("FAIL stagger0 step=%0d got=%b exp=%b", s, got, t_exp[s]);
            end
        end
        req1 = 1'b0; ack1 = '0;
    endtask

    initial begin
        @(negedge clk_fr);
        test_reset();
        test_power_on();
        test_sw_reset();
        test_timeout();
        test_rst_in_quiesce();
        test_random();
        test_stagger0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset/clock-enable sequencer for the testbench clock-reset infrastructure. Holds a set of downstream reset domains in reset after power-on, enables their clocks, then releases their active-low resets in a staggered order. Services software reset requests with a quiesce handshake and a timeout. Sits between the free-running clock/reset source and the per-domain gated clocks and resets feeding the DUT and bench agents.

## Interface
- NUM_DOM, 4, number of reset domains (1..16)
- RST_CYCLES, 5, clock edges spent in HOLD before first release (>=1)
- STAGGER, 2, edges between consecutive domain releases (0 = release all together)
- QUIESCE_TIMEOUT, 64, max edges spent in QUIESCE (>=1)

- clk_fr  in  1  free-running clock; all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- sw_rst_req  in  1  software reset request, sampled only in RUN
- quiesce_ack  in  NUM_DOM  per-domain "idle, safe to reset"
- sw_rst_ack  out  1  one-cycle pulse: software reset sequence complete
- quiesce_req  out  1  request to all domains to go idle
- dom_clk_en  out  NUM_DOM  per-domain clock enable
- dom_rst_n  out  NUM_DOM  per-domain active-low reset
- busy  out  1  high whenever state != RUN
- timeout_err  out  1  sticky: a quiesce timed out
- state  out  3  debug: HOLD=0, RELEASE=1, RUN=2, QUIESCE=3, ASSERT=4

## Operation
- All outputs registered. Reset values (rst sampled high): state=HOLD, dom_rst_n=0, dom_clk_en=0, quiesce_req=0, sw_rst_ack=0, busy=1, timeout_err=0. Internal counters and the sw flag are also cleared.
- HOLD:
  - Each edge sets dom_clk_en to all ones and increments cnt.
  - On the RST_CYCLES-th edge in HOLD, go to RELEASE and set dom_rst_n[0]=1 on that same edge. If STAGGER=0, set all bits.
- RELEASE:
  - dom_rst_n[i] rises STAGGER edges after dom_rst_n[i-1].
  - The edge after the last domain is released enters RUN: busy=0.
  - sw_rst_ack=1 on that edge if the sw flag is set; the flag clears.
- RUN:
  - sw_rst_req=1 at an edge: enter QUIESCE, quiesce_req=1, busy=1, sw flag=1, cnt=0.
  - sw_rst_req is ignored (not queued) in every other state.
- QUIESCE, evaluated each edge:
  - If &quiesce_ack: enter ASSERT.
  - Else if cnt==QUIESCE_TIMEOUT-1: enter ASSERT and set timeout_err=1.
  - Else cnt++.
  - Ack and timeout on the same edge: ack wins, no error.
- ASSERT: the entry edge sets quiesce_req=0, dom_rst_n=0, dom_clk_en=0. The next edge enters HOLD with cnt=0. That edge does not count as a HOLD edge.
- timeout_err clears only on rst.
- rst is sampled high in any state, including mid-RELEASE or mid-QUIESCE: full reset values on that edge, the sw flag is dropped, and no sw_rst_ack is issued.
- Counters are sized $clog2 of the larger of RST_CYCLES, STAGGER*NUM_DOM and QUIESCE_TIMEOUT, plus 1. No wrap is possible.

## Timing
- Edge numbering: edge 1 = first rising edge with rst sampled low.
- Power-on, defaults:
  - dom_clk_en=1111 after edge 1.
  - dom_rst_n[0..3] rise after edges 5, 7, 9, 11.
  - busy=0 and state=RUN after edge 12.
- General release timing:
  - dom_rst_n[i] rises after edge RST_CYCLES + i*STAGGER.
  - RUN is entered after edge RST_CYCLES + (NUM_DOM-1)*STAGGER + 1.
- Software reset, req sampled at edge E:
  - quiesce_req=1 after E.
  - Ack sampled at edge E+k gives ASSERT after E+k and HOLD after E+k+1.
  - Release then follows the power-on offsets, counted from E+k+1.
- quiesce_ack is unregistered into the FSM: single-edge latency from ack to ASSERT.

## Test plan
- Power-on, defaults, rst high 3 edges -> after edge 1 clk_en=1111; rst_n bits rise after edges 5/7/9/11; busy falls after edge 12; sw_rst_ack never pulses.
- sw_rst_req pulse in RUN at edge E, quiesce_ack=1111 at E+3 -> ASSERT after E+3 (rst_n=0000, clk_en=0000); HOLD after E+4; rst_n[0] rises after E+9; RUN plus one-cycle sw_rst_ack after E+16; timeout_err=0.
- sw_rst_req in RUN, quiesce_ack held 0111 -> exactly 64 edges in QUIESCE, then ASSERT with timeout_err=1; the bit stays 1 through a full re-release and a later clean sw reset.
- sw_rst_req held high during HOLD/RELEASE after power-on, dropped before RUN -> no QUIESCE entry; RUN reached at edge 12.
- rst asserted while in QUIESCE, then rst low -> reset values on the rst edge; full power-on sequence repeats; no sw_rst_ack at the following RUN entry.
- STAGGER=0, NUM_DOM=3, RST_CYCLES=1 -> all rst_n rise after edge 1; RUN after edge 2. Ack and timeout coincident with QUIESCE_TIMEOUT=1 and ack=111 -> no timeout_err.
